// File: rtl/op_pkg.sv
// Shared definitions for the op_mod / op_mod_recon pair: default operand width and
// the reconstruction controller states.
package op_pkg;

    localparam int OP_N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } recon_state_t;

endpackage

// File: rtl/op_mod_recon.sv
// Rebuilds a dividend Z = Q*B + R from quotient, divisor and remainder using a
// shift-add multiplier that retires one multiplier bit per clock.
module op_mod_recon
    import op_pkg::*;
#(
    parameter int N = OP_N
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [N-1:0]   i_q,
    input  logic [N-1:0]   i_b,
    input  logic [N-1:0]   i_r,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_z
);

    localparam int CW = $clog2(N + 1);

    recon_state_t   r_state;
    logic [N-1:0]   r_mq;
    logic [2*N-1:0] r_mc;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [2*N-1:0] r_z;
    logic [2*N-1:0] w_acc_next;

    // Seeding acc with R folds the remainder in for free; the sum cannot exceed 2N bits.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mq[0]) begin
            w_acc_next = r_acc + r_mc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_mq    <= '0;
            r_mc    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_mq    <= i_q;
                    r_mc    <= {{N{1'b0}}, i_b};
                    r_acc   <= {{N{1'b0}}, i_r};
                    r_cnt   <= CW'(N);
                    r_busy  <= 1'b1;
                    r_state <= CALC;
                end
            end else begin
                r_acc <= w_acc_next;
                r_mc  <= r_mc << 1;
                r_mq  <= r_mq >> 1;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_z     <= w_acc_next;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_z    = r_z;

endmodule

// File: tb/tb_op_mod_recon.sv
// Directed and randomized checks of op_mod_recon against plain arithmetic Q*B+R,
// including latency, handshake, abort-on-reset and the divide/modulo round trip.
module tb_op_mod_recon;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   q_in;
    logic [N-1:0]   b_in;
    logic [N-1:0]   r_in;
    logic           busy;
    logic           done;
    logic [2*N-1:0] z;

    int total = 0;
    int bad   = 0;

    op_mod_recon #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_q     (q_in),
        .i_b     (b_in),
        .i_r     (r_in),
        .o_busy  (busy),
        .o_done  (done),
        .o_z     (z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for done after an accepted start edge; returns edges elapsed (99 if it never came).
    task automatic wait_done(output int lat, output int busy_gaps);
        lat = 0;
        busy_gaps = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_gaps++;
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = 99;
    endtask

    task automatic run_op(input int q, input int b, input int r, input string tag);
        int lat;
        int gaps;
        @(negedge clk);
        start = 1'b1;
        q_in  = N'(q);
        b_in  = N'(b);
        r_in  = N'(r);
        @(posedge clk); #1;
        start = 1'b0;
        q_in  = N'($urandom);
        b_in  = N'($urandom);
        r_in  = N'($urandom);
        wait_done(lat, gaps);
        check({tag, "_lat"}, lat, N);
        check({tag, "_busygap"}, gaps, 0);
        check({tag, "_z"}, z, q * b + r);
        check({tag, "_busy_at_done"}, busy, 0);
        $display("op %s: Q=%0d B=%0d R=%0d -> Z=%0d latency=%0d", tag, q, b, r, z, lat);
    endtask

    initial begin
        int lat;
        int gaps;
        int ndone;
        int first_lat;
        logic [2*N-1:0] z_seen;

        rst   = 1'b1;
        start = 1'b0;
        q_in  = '0;
        b_in  = '0;
        r_in  = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_z", z, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_done", done, 0);

        run_op(3, 5, 2, "basic");
        run_op(15, 15, 14, "max");
        run_op(0, 9, 7, "q_zero");
        run_op(6, 0, 3, "b_zero");
        run_op(0, 0, 0, "all_zero");

        // Second start two cycles into an operation must be ignored.
        @(negedge clk);
        start = 1'b1; q_in = 4'd2; b_in = 4'd4; r_in = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; q_in = 4'd1; b_in = 4'd1; r_in = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_lat = 0; z_seen = '0;
        for (int i = 3; i <= 12; i++) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = i - 1;
                    z_seen = z;
                end
            end
            @(posedge clk); #1;
        end
        check("busystart_ndone", ndone, 1);
        check("busystart_lat", first_lat, N);
        check("busystart_z", z_seen, 9);
        $display("op busystart: Z=%0d dones=%0d", z_seen, ndone);

        // Asynchronous reset during CALC aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; q_in = 4'd7; b_in = 4'd3; r_in = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy_before", busy, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_z", z, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        $display("op abort: Z=%0d dones_after=%0d", z, ndone);

        // Start held high through the done cycle: next op accepted at the following edge.
        @(negedge clk);
        start = 1'b1; q_in = 4'd9; b_in = 4'd11; r_in = 4'd5;
        @(posedge clk); #1;
        q_in = 4'd13; b_in = 4'd6; r_in = 4'd10;
        wait_done(lat, gaps);
        check("b2b_first_lat", lat, N);
        check("b2b_first_z", z, 9 * 11 + 5);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        wait_done(lat, gaps);
        check("b2b_second_lat", lat, N);
        check("b2b_second_z", z, 13 * 6 + 10);
        $display("op back2back: Z=%0d", z);

        // Round trip through divide/modulo must rebuild the dividend.
        for (int a = 0; a < 16; a++) begin
            for (int d = 1; d < 16; d++) begin
                run_op(a / d, d, a % d, $sformatf("rt_a%0d_b%0d", a, d));
            end
        end

        for (int i = 0; i < 150; i++) begin
            run_op(int'($urandom_range(15)), int'($urandom_range(15)),
                   int'($urandom_range(15)), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
